ff_layer_seq: RTL and testbench
===============================

Name: ff_layer_seq

Overview:
- Parametrised, bus-programmable fully-connected network layer; successor to the fixed 2-2-2 ff_network core.
- Weights and inputs are loaded through the same address/in_d/write/read register interface the network uses.
- A start command computes N_OUT neurons with one time-shared multiply-accumulate (MAC) unit, then applies a hard-sigmoid activation.
- Instances chain into multi-layer networks under a host controller.

Parameters:
- N_IN, 2, inputs per neuron (>=1)
- N_OUT, 2, neurons in layer (>=1)
- WIDTH, 32, bus data width
- WIDTH_I, 10, input value width, unsigned
- WIDTH_W, 4, weight width, signed two's complement
- RANGE_SIGM, 512, activation output range [0, RANGE_SIGM-1], power of two
- SHIFT, 2, arithmetic right shift applied to accumulator before activation
- WIDTH_O, $clog2(RANGE_SIGM), output width (derived)
- WIDTH_SM, WIDTH_I+WIDTH_W+1+$clog2(N_IN), accumulator width, signed (derived)
- WIDTH_ADDR, $clog2(N_IN*N_OUT+N_IN+2+N_OUT), address width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- in_d  in  WIDTH  write data
- address  in  WIDTH_ADDR  register address
- write  in  1  write strobe, sampled each rising edge
- read  in  1  read strobe, sampled each rising edge
- out_d  out  WIDTH  read data, zero-extended
- ready  out  1  read-data valid, one cycle
- down  out  1  computation-complete pulse, one cycle

Behaviour:
- Register map, base offsets:
  - W[j][i] at j*N_IN+i, read/write; in_d[WIDTH_W-1:0] stored as signed.
  - X[i] at N_IN*N_OUT+i, read/write; in_d[WIDTH_I-1:0] stored.
  - CTRL at N_IN*N_OUT+N_IN, write-only; writing bit0=1 starts a computation.
  - STATUS at CTRL+1, read-only; bit0 busy, bit1 done (sticky).
  - Y[j] at CTRL+2+j, read-only.
  - Writes to read-only or unmapped addresses are ignored; reads of unmapped or write-only addresses return 0.
- Reset: all W, X and Y = 0; busy=0, done=0, out_d=0, ready=0, down=0; state=IDLE. Reset mid-computation aborts the computation immediately, with no down pulse.
- Read timing: read asserted at edge t gives out_d valid and ready=1 after edge t (one-cycle latency). out_d holds that value until the next read. Reads are always allowed, including while busy.
- Read and write in the same cycle: the write takes effect; the read returns the pre-write value.
- State machine IDLE -> MAC -> ACT -> (MAC | DONE) -> IDLE:
  - IDLE: a CTRL start write sets busy=1, clears done, zeroes acc, sets j=0, i=0, and moves to MAC.
  - MAC: acc += signed(X[i]) * W[j][i], with X zero-extended. i increments; after i=N_IN-1, move to ACT.
  - ACT: Y[j] = clamp((acc >>> SHIFT) + RANGE_SIGM/2, 0, RANGE_SIGM-1). acc clears, i=0, j increments. If j was N_OUT-1, move to DONE; otherwise move to MAC.
  - DONE: down=1 for one cycle, busy=0, done=1, then IDLE.
- Latency: down is high exactly N_OUT*(N_IN+1)+1 cycles after the start-write edge.
- While busy, writes to W, X or CTRL are dropped, so a start is ignored. Y[j] updates per neuron; earlier Y values persist until overwritten.
- The shift is arithmetic (floor). The clamp is applied on full WIDTH_SM precision with no intermediate overflow.

Decomposition:
- Package ff_net_pkg holds:
  - the state enum (IDLE, MAC, ACT, DONE);
  - address-offset functions (w_addr, x_addr, ctrl_addr, status_addr, y_addr);
  - the STATUS bit indices.
- One sub-module, ff_hard_sigm: combinational shift, offset and clamp; parameters WIDTH_SM, SHIFT, RANGE_SIGM.

Test Plan:
All scenarios use defaults, so the address map is W 0-3, X 4-5, CTRL 6, STATUS 7, Y 8-9.
- Basic compute: write W={1,2,-1,-3}, X={10,20}, CTRL=1 -> down 7 cycles after start; read Y0=268, Y1=238; STATUS=0b10.
- Saturation: X={1023,1023}, W0={7,7}, W1={-8,-8}, start -> Y0=511, Y1=0.
- Busy protection: start, then write X0=5 and CTRL=1 while busy -> X0 reads back old value; exactly one down pulse; results unchanged from the first run.
- Read/write handshake: read address 4 at the same edge as write 4=77 -> ready next cycle with old value; the following read returns 77. Read address 12 -> out_d=0 with ready=1.
- Reset mid-run: assert reset 3 cycles after start -> no down pulse; all registers read 0; STATUS=0.
- Back-to-back: start again in the cycle after down -> second down 7 cycles later; done clears at the second start.

Source files
------------

// File: rtl/ff_net_pkg.sv
// Shared definitions for the bus-programmable feed-forward layer: FSM states,
// register-map offset helpers and STATUS bit positions.
package ff_net_pkg;

    typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;

    function automatic int w_addr(input int n_in, input int j, input int i);
        return j * n_in + i;
    endfunction

    function automatic int x_addr(input int n_in, input int n_out, input int i);
        return n_in * n_out + i;
    endfunction

    function automatic int ctrl_addr(input int n_in, input int n_out);
        return n_in * n_out + n_in;
    endfunction

    function automatic int status_addr(input int n_in, input int n_out);
        return ctrl_addr(n_in, n_out) + 1;
    endfunction

    function automatic int y_addr(input int n_in, input int n_out, input int j);
        return ctrl_addr(n_in, n_out) + 2 + j;
    endfunction

endpackage

// File: rtl/ff_hard_sigm.sv
// Hard-sigmoid activation: arithmetic shift, re-centre on RANGE_SIGM/2 and
// clamp to [0, RANGE_SIGM-1], all on a widened signed datapath.
module ff_hard_sigm #(
    parameter int WIDTH_SM   = 16,
    parameter int SHIFT      = 2,
    parameter int RANGE_SIGM = 512,
    parameter int WIDTH_O    = $clog2(RANGE_SIGM)
) (
    input  logic signed [WIDTH_SM-1:0] acc,
    output logic        [WIDTH_O-1:0]  y
);

    // One guard bit above the larger of accumulator and offset so the add never wraps.
    localparam int WS = ((WIDTH_SM > WIDTH_O + 1) ? WIDTH_SM : WIDTH_O + 1) + 1;
    localparam logic signed [WS-1:0] HALF = WS'(RANGE_SIGM / 2);
    localparam logic signed [WS-1:0] MAXV = WS'(RANGE_SIGM - 1);

    logic signed [WIDTH_SM-1:0] shifted;
    logic signed [WS-1:0]       sum;

    always_comb begin
        shifted = acc >>> SHIFT;
        sum     = WS'(shifted) + HALF;
        if (sum[WS-1])
            y = '0;
        else if (sum > MAXV)
            y = '1;
        else
            y = sum[WIDTH_O-1:0];
    end

endmodule

// File: rtl/ff_layer_seq.sv
// Fully-connected layer with register-mapped weights/inputs and a single
// time-shared MAC; results pass through a hard sigmoid into Y registers.
module ff_layer_seq
    import ff_net_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int N_OUT      = 2,
    parameter int WIDTH      = 32,
    parameter int WIDTH_I    = 10,
    parameter int WIDTH_W    = 4,
    parameter int RANGE_SIGM = 512,
    parameter int SHIFT      = 2,
    parameter int WIDTH_O    = $clog2(RANGE_SIGM),
    parameter int WIDTH_SM   = WIDTH_I + WIDTH_W + 1 + $clog2(N_IN),
    parameter int WIDTH_ADDR = $clog2(N_IN*N_OUT + N_IN + 2 + N_OUT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_d,
    input  logic [WIDTH_ADDR-1:0] address,
    input  logic                  write,
    input  logic                  read,
    output logic [WIDTH-1:0]      out_d,
    output logic                  ready,
    output logic                  down
);

    localparam int N_W = N_IN * N_OUT;
    localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int WIW = (N_W > 1) ? $clog2(N_W) : 1;

    logic signed [WIDTH_W-1:0]  w_reg [N_W];
    logic        [WIDTH_I-1:0]  x_reg [N_IN];
    logic        [WIDTH_O-1:0]  y_reg [N_OUT];
    logic signed [WIDTH_SM-1:0] acc_reg;
    logic        [IW-1:0]       i_reg;
    logic        [JW-1:0]       j_reg;
    state_t                     state_reg;
    logic                       busy_reg, done_reg, down_reg, ready_reg;
    logic        [WIDTH-1:0]    out_d_reg;

    logic        [WIDTH-1:0]    rdata;
    logic        [WIW-1:0]      widx;
    logic signed [WIDTH_SM-1:0] x_ext, w_ext, prod;
    logic        [WIDTH_O-1:0]  y_act;
    logic                       bus_wr, start;
    logic        [N_W-1:0]      wr_w;
    logic        [N_IN-1:0]     wr_x;
    logic                       unused_in;

    assign unused_in = ^in_d[WIDTH-1:WIDTH_I];
    assign bus_wr    = write && !busy_reg;
    assign start     = bus_wr && in_d[0]
                       && (address == WIDTH_ADDR'(ctrl_addr(N_IN, N_OUT)));

    generate
        for (genvar gi = 0; gi < N_W; gi++) begin : g_wr_w
            assign wr_w[gi] = bus_wr
                && (address == WIDTH_ADDR'(w_addr(N_IN, gi / N_IN, gi % N_IN)));
        end
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_wr_x
            assign wr_x[gi] = bus_wr && (address == WIDTH_ADDR'(x_addr(N_IN, N_OUT, gi)));
        end
    endgenerate

    // X is unsigned, so it is zero-extended before the signed multiply.
    always_comb begin
        widx  = WIW'(int'(j_reg) * N_IN + int'(i_reg));
        x_ext = WIDTH_SM'(x_reg[i_reg]);
        w_ext = WIDTH_SM'(w_reg[widx]);
        prod  = x_ext * w_ext;
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < N_W; k++)
            if (address == WIDTH_ADDR'(w_addr(N_IN, k / N_IN, k % N_IN)))
                rdata = {{(WIDTH-WIDTH_W){1'b0}}, w_reg[k]};
        for (int k = 0; k < N_IN; k++)
            if (address == WIDTH_ADDR'(x_addr(N_IN, N_OUT, k)))
                rdata = {{(WIDTH-WIDTH_I){1'b0}}, x_reg[k]};
        for (int k = 0; k < N_OUT; k++)
            if (address == WIDTH_ADDR'(y_addr(N_IN, N_OUT, k)))
                rdata = {{(WIDTH-WIDTH_O){1'b0}}, y_reg[k]};
        if (address == WIDTH_ADDR'(status_addr(N_IN, N_OUT))) begin
            rdata[STATUS_BUSY] = busy_reg;
            rdata[STATUS_DONE] = done_reg;
        end
    end

    ff_hard_sigm #(
        .WIDTH_SM  (WIDTH_SM),
        .SHIFT     (SHIFT),
        .RANGE_SIGM(RANGE_SIGM),
        .WIDTH_O   (WIDTH_O)
    ) u_sigm (
        .acc(acc_reg),
        .y  (y_act)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_W; k++)   w_reg[k] <= '0;
            for (int k = 0; k < N_IN; k++)  x_reg[k] <= '0;
            for (int k = 0; k < N_OUT; k++) y_reg[k] <= '0;
            acc_reg   <= '0;
            i_reg     <= '0;
            j_reg     <= '0;
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            down_reg  <= 1'b0;
            ready_reg <= 1'b0;
            out_d_reg <= '0;
        end else begin
            // rdata reflects pre-write contents, so a same-cycle write is not visible here.
            ready_reg <= read;
            if (read) out_d_reg <= rdata;
            down_reg <= 1'b0;
            for (int k = 0; k < N_W; k++)
                if (wr_w[k]) w_reg[k] <= in_d[WIDTH_W-1:0];
            for (int k = 0; k < N_IN; k++)
                if (wr_x[k]) x_reg[k] <= in_d[WIDTH_I-1:0];

            case (state_reg)
                IDLE: if (start) begin
                    busy_reg  <= 1'b1;
                    done_reg  <= 1'b0;
                    acc_reg   <= '0;
                    i_reg     <= '0;
                    j_reg     <= '0;
                    state_reg <= MAC;
                end
                MAC: begin
                    acc_reg <= acc_reg + prod;
                    if (i_reg == IW'(N_IN - 1)) begin
                        i_reg     <= '0;
                        state_reg <= ACT;
                    end else begin
                        i_reg <= i_reg + 1'b1;
                    end
                end
                ACT: begin
                    y_reg[j_reg] <= y_act;
                    acc_reg      <= '0;
                    i_reg        <= '0;
                    if (j_reg == JW'(N_OUT - 1)) begin
                        j_reg     <= '0;
                        state_reg <= DONE;
                    end else begin
                        j_reg     <= j_reg + 1'b1;
                        state_reg <= MAC;
                    end
                end
                DONE: begin
                    down_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_d = out_d_reg;
    assign ready = ready_reg;
    assign down  = down_reg;

endmodule

// File: tb/tb_ff_layer_seq.sv
// Self-checking bench for ff_layer_seq (default parameters) against an
// arithmetic model of the layer computed from the register contents.
module tb_ff_layer_seq;

    localparam int N_IN = 2, N_OUT = 2;
    localparam int CTRL = 6, STATUS = 7, Y0 = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_d;
    logic [3:0]  address;
    logic        write, read;
    logic [31:0] out_d;
    logic        ready, down;

    ff_layer_seq dut (
        .clk    (clk),
        .reset  (reset),
        .in_d   (in_d),
        .address(address),
        .write  (write),
        .read   (read),
        .out_d  (out_d),
        .ready  (ready),
        .down   (down)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, down_count = 0, down_cyc = 0;
    int mw [N_IN*N_OUT];
    int mx [N_IN];
    int my [N_OUT];
    bit m_done;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        if (down) begin
            down_count++;
            down_cyc = cyc;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Neuron value: weighted sum, floor-divide by 2^SHIFT, centre, clamp.
    function automatic int model_neuron(input int j);
        int acc, sh, v;
        acc = 0;
        for (int i = 0; i < N_IN; i++) acc += mx[i] * mw[j*N_IN + i];
        sh = (acc >= 0) ? acc / 4 : -((-acc + 3) / 4);
        v  = sh + 256;
        if (v < 0) v = 0;
        if (v > 511) v = 511;
        return v;
    endfunction

    task automatic bus_write(input int a, input logic [31:0] d);
        address = a[3:0];
        in_d    = d;
        write   = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic expect_read(input string tag, input int a, input longint exp);
        address = a[3:0];
        read    = 1'b1;
        @(negedge clk);
        read = 1'b0;
        check({tag, "_ready"}, ready, 1);
        check(tag, out_d, exp);
    endtask

    task automatic write_w(input int j, input int i, input int val);
        logic [31:0] d;
        d = $urandom;
        d[3:0] = val[3:0];
        mw[j*N_IN + i] = val;
        bus_write(j*N_IN + i, d);
    endtask

    task automatic write_x(input int i, input int val);
        logic [31:0] d;
        d = $urandom;
        d[9:0] = val[9:0];
        mx[i] = val;
        bus_write(N_IN*N_OUT + i, d);
    endtask

    task automatic wait_down(input string tag, input int dc0, input int st);
        for (int k = 0; k < 40 && down_count == dc0; k++) @(negedge clk);
        check({tag, "_down"}, down_count - dc0, 1);
        check({tag, "_latency"}, down_cyc - st, 7);
        for (int j = 0; j < N_OUT; j++) my[j] = model_neuron(j);
        m_done = 1'b1;
    endtask

    task automatic start_and_wait(input string tag);
        int dc0, st;
        dc0 = down_count;
        bus_write(CTRL, 32'h1);
        st = cyc;
        wait_down(tag, dc0, st);
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < N_IN*N_OUT; k++) expect_read({tag, "_w"}, k, mw[k] & 15);
        for (int k = 0; k < N_IN; k++) expect_read({tag, "_x"}, N_IN*N_OUT + k, mx[k]);
        for (int k = 0; k < N_OUT; k++) expect_read({tag, "_y"}, Y0 + k, my[k]);
        expect_read({tag, "_status"}, STATUS, m_done ? 2 : 0);
    endtask

    task automatic clear_model();
        foreach (mw[k]) mw[k] = 0;
        foreach (mx[k]) mx[k] = 0;
        foreach (my[k]) my[k] = 0;
        m_done = 1'b0;
    endtask

    initial begin
        int dc0, st;
        reset = 1'b1; write = 1'b0; read = 1'b0; address = '0; in_d = '0;
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_down", down, 0);
        check("rst_out_d", out_d, 0);
        reset = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 16; a++) expect_read("rst_reg", a, 0);

        // Basic compute
        write_w(0, 0, 1); write_w(0, 1, 2); write_w(1, 0, -1); write_w(1, 1, -3);
        write_x(0, 10); write_x(1, 20);
        start_and_wait("basic");
        expect_read("basic_y0", Y0, 268);
        expect_read("basic_y1", Y0 + 1, 238);
        expect_read("basic_status", STATUS, 2);
        check_all("basic");

        // Saturation at both ends
        write_x(0, 1023); write_x(1, 1023);
        write_w(0, 0, 7); write_w(0, 1, 7); write_w(1, 0, -8); write_w(1, 1, -8);
        start_and_wait("sat");
        expect_read("sat_y0", Y0, 511);
        expect_read("sat_y1", Y0 + 1, 0);

        // Writes and a second start while busy are dropped
        dc0 = down_count;
        bus_write(CTRL, 32'h1);
        st = cyc;
        bus_write(N_IN*N_OUT, 32'd5);
        bus_write(CTRL, 32'h1);
        expect_read("busy_status", STATUS, 1);
        wait_down("busy", dc0, st);
        repeat (12) @(negedge clk);
        check("busy_one_pulse", down_count - dc0, 1);
        expect_read("busy_x0", N_IN*N_OUT, 1023);
        check_all("busy");

        // Same-edge read and write of X0
        address = 4'd4; in_d = 32'd77; write = 1'b1; read = 1'b1;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        check("rw_ready", ready, 1);
        check("rw_old", out_d, 1023);
        mx[0] = 77;
        expect_read("rw_new", 4, 77);
        expect_read("unmapped", 12, 0);
        expect_read("ctrl_read", CTRL, 0);
        bus_write(Y0, 32'd99);
        bus_write(STATUS, 32'hFFFF);
        expect_read("ro_y0", Y0, my[0]);
        expect_read("ro_status", STATUS, 2);

        // Back-to-back starts
        start_and_wait("b2b_first");
        dc0 = down_count;
        bus_write(CTRL, 32'h1);
        st = cyc;
        expect_read("b2b_status", STATUS, 1);
        wait_down("b2b_second", dc0, st);
        check_all("b2b");

        // Randomized layers
        for (int n = 0; n < 15; n++) begin
            for (int j = 0; j < N_OUT; j++)
                for (int i = 0; i < N_IN; i++)
                    write_w(j, i, int'($urandom_range(15)) - 8);
            for (int i = 0; i < N_IN; i++) write_x(i, int'($urandom_range(1023)));
            start_and_wait("rand");
            check_all("rand");
        end

        // Reset in the middle of a computation
        dc0 = down_count;
        bus_write(CTRL, 32'h1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ready", ready, 0);
        check("midrst_out_d", out_d, 0);
        reset = 1'b0;
        clear_model();
        repeat (15) @(negedge clk);
        check("midrst_no_down", down_count - dc0, 0);
        check_all("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
